accumulate_pipe: RTL and testbench

//  Pipelined, handshaked successor of the combinational mantissa add/sub unit in the MAF datapath.

---
 rtl/accumulate_pipe_if.sv | 39 +++
 rtl/accumulate_pipe.sv | 198 +++++++++++++++++++
 tb/tb_accumulate_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulate_pipe_if.sv
// accumulate_pipe_if
//   Bundles the beat-in and result-out handshakes of accumulate_pipe.
//   master : upstream/downstream side (drives operands and ready_i)
//   slave  : the accumulate_pipe block itself
//   Signals
//     valid_i / ready_o         input beat handshake
//     ab_number_i, c_number_i   product and addend mantissas
//     sub, acc_mode_i, last_i   per-beat operation controls
//     valid_o / ready_i         result handshake
//     acc_resulting_number_o    result magnitude, MSB is the carry
//     swap_o, ovf, count_o      result sign/swap, overflow, folded-term count
interface accumulate_pipe_if #(
  parameter int size_mul_mantissa = 48,
  parameter int size_counter      = 5
);
  logic                         valid_i;
  logic                         ready_o;
  logic [size_mul_mantissa-1:0] ab_number_i;
  logic [size_mul_mantissa-1:0] c_number_i;
  logic                         sub;
  logic                         acc_mode_i;
  logic                         last_i;
  logic                         valid_o;
  logic                         ready_i;
  logic [size_mul_mantissa:0]   acc_resulting_number_o;
  logic                         swap_o;
  logic                         ovf;
  logic [size_counter-1:0]      count_o;

  modport master (
    output valid_i, ab_number_i, c_number_i, sub, acc_mode_i, last_i, ready_i,
    input  ready_o, valid_o, acc_resulting_number_o, swap_o, ovf, count_o
  );

  modport slave (
    input  valid_i, ab_number_i, c_number_i, sub, acc_mode_i, last_i, ready_i,
    output ready_o, valid_o, acc_resulting_number_o, swap_o, ovf, count_o
  );
endinterface

// File: rtl/accumulate_pipe.sv
// accumulate_pipe
//   Two-stage handshaked mantissa add/sub unit between the mantissa
//   multiplier and the normaliser/rounder.
//   Pass mode       : emits |ab +/- c| per beat, latency 2, 1 beat/clk.
//   Accumulate mode : folds +/-ab terms into a sign-magnitude accumulator
//                     and emits it on the last term of the stream.
//   Ports
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  accumulate_pipe_if.slave (beat in, result out, see interface)
module accumulate_pipe #(
  parameter int size_mantissa     = 24,
  parameter int size_counter      = 5,
  parameter int size_mul_mantissa = 2 * size_mantissa
) (
  input  logic              clk,
  input  logic              rst,
  accumulate_pipe_if.slave  bus
);

  localparam int W  = size_mul_mantissa;
  localparam int CW = size_counter;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  // Unsigned add that clamps to all ones on carry-out; the MSB of the
  // returned value flags that the clamp happened.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[W]) sat_add = {1'b1, {W{1'b1}}};
    else      sat_add = s;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (&v) ? v : v + CW'(1);
  endfunction

  state_t          state_q;

  logic            vld_p1_q;
  logic [W-1:0]    ab_p1_q;
  logic [W-1:0]    c_p1_q;
  logic            ge_p1_q;
  logic            sub_p1_q;
  logic            acc_p1_q;
  logic            last_p1_q;

  logic            vld_p2_q;
  logic [W:0]      res_p2_q;
  logic            swap_p2_q;
  logic            ovf_p2_q;
  logic [CW-1:0]   cnt_p2_q;

  logic [W-1:0]    acc_mag_q;
  logic            acc_neg_q;
  logic            acc_ovf_q;
  logic [CW-1:0]   term_cnt_q;

  logic            s1_adv;
  logic            s2_load;
  logic            ready_w;
  logic            accept;
  logic [W-1:0]    cmp_rhs;
  logic [W:0]      sat_sum;

  logic [W:0]      pass_res_d;
  logic            pass_swap_d;
  logic            pass_ovf_d;
  logic [W-1:0]    acc_mag_d;
  logic            acc_neg_d;
  logic            acc_ovf_d;
  logic [CW-1:0]   term_cnt_d;

  assign s1_adv  = !vld_p2_q || bus.ready_i;
  assign s2_load = vld_p1_q && s1_adv;
  // Only IDLE takes beats: BUSY has an accumulate term in flight and HOLD
  // is waiting for its result to be taken.
  assign ready_w = (state_q == IDLE) && (!vld_p1_q || s1_adv);
  assign accept  = bus.valid_i && ready_w;

  // The accumulator is stable whenever a beat can be accepted, so the
  // accumulate-mode compare can be taken here against the live value.
  assign cmp_rhs = bus.acc_mode_i ? acc_mag_q : bus.c_number_i;

  // ---- S1: operand, compare and mode capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      ab_p1_q   <= bus.ab_number_i;
      c_p1_q    <= bus.c_number_i;
      ge_p1_q   <= (bus.ab_number_i >= cmp_rhs);
      sub_p1_q  <= bus.sub;
      acc_p1_q  <= bus.acc_mode_i;
      last_p1_q <= bus.last_i;
    end
  end

  // ---- S2: result computation ----
  always_comb begin
    pass_res_d  = '0;
    pass_swap_d = 1'b0;
    pass_ovf_d  = 1'b0;
    if (!sub_p1_q) begin
      pass_res_d = {1'b0, ab_p1_q} + {1'b0, c_p1_q};
      pass_ovf_d = pass_res_d[W];
    end else if (ge_p1_q) begin
      pass_res_d = {1'b0, ab_p1_q - c_p1_q};
    end else begin
      pass_res_d  = {1'b0, c_p1_q - ab_p1_q};
      pass_swap_d = 1'b1;
    end
  end

  assign sat_sum    = sat_add(acc_mag_q, ab_p1_q);
  assign term_cnt_d = sat_inc(term_cnt_q);

  always_comb begin
    acc_mag_d = acc_mag_q;
    acc_neg_d = acc_neg_q;
    acc_ovf_d = acc_ovf_q;
    if (sub_p1_q == acc_neg_q) begin
      acc_mag_d = sat_sum[W-1:0];
      acc_ovf_d = acc_ovf_q | sat_sum[W];
    end else if (ge_p1_q) begin
      // Term magnitude dominates: sign flips unless the result is zero.
      acc_mag_d = ab_p1_q - acc_mag_q;
      acc_neg_d = (acc_mag_d != '0) ? !acc_neg_q : 1'b0;
    end else begin
      acc_mag_d = acc_mag_q - ab_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      res_p2_q   <= '0;
      swap_p2_q  <= 1'b0;
      ovf_p2_q   <= 1'b0;
      cnt_p2_q   <= '0;
      acc_mag_q  <= '0;
      acc_neg_q  <= 1'b0;
      acc_ovf_q  <= 1'b0;
      term_cnt_q <= '0;
    end else begin
      vld_p1_q <= accept || (vld_p1_q && !s1_adv);

      if (s2_load) begin
        if (!acc_p1_q) begin
          vld_p2_q  <= 1'b1;
          res_p2_q  <= pass_res_d;
          swap_p2_q <= pass_swap_d;
          ovf_p2_q  <= pass_ovf_d;
          cnt_p2_q  <= CW'(1);
        end else begin
          acc_mag_q  <= acc_mag_d;
          acc_neg_q  <= acc_neg_d;
          acc_ovf_q  <= acc_ovf_d;
          term_cnt_q <= term_cnt_d;
          vld_p2_q   <= last_p1_q;
          if (last_p1_q) begin
            res_p2_q  <= {1'b0, acc_mag_d};
            swap_p2_q <= acc_neg_d;
            ovf_p2_q  <= acc_ovf_d;
            cnt_p2_q  <= term_cnt_d;
          end
        end
      end else if (bus.ready_i) begin
        vld_p2_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (accept && bus.acc_mode_i) state_q <= BUSY;
        BUSY: if (s2_load) state_q <= last_p1_q ? HOLD : IDLE;
        HOLD: begin
          // S1 is empty in HOLD, so this clear never races an update.
          if (bus.ready_i) begin
            state_q    <= IDLE;
            acc_mag_q  <= '0;
            acc_neg_q  <= 1'b0;
            acc_ovf_q  <= 1'b0;
            term_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o                = ready_w;
  assign bus.valid_o                = vld_p2_q;
  assign bus.acc_resulting_number_o = res_p2_q;
  assign bus.swap_o                 = swap_p2_q;
  assign bus.ovf                    = ovf_p2_q;
  assign bus.count_o                = cnt_p2_q;

endmodule

// File: tb/tb_accumulate_pipe.sv
module tb_accumulate_pipe;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  accumulate_pipe_if bus ();

  accumulate_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Presents one beat and holds it until accepted. Returns 2 time units
  // after the accepting clock edge with valid_i dropped.
  task automatic drive_beat(input logic [47:0] ab, input logic [47:0] c,
                            input logic sb, input logic acc, input logic lst);
    bit done;
    done = 1'b0;
    bus.ab_number_i = ab;
    bus.c_number_i  = c;
    bus.sub         = sb;
    bus.acc_mode_i  = acc;
    bus.last_i      = lst;
    bus.valid_i     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_o === 1'b1) begin
        @(posedge clk); #2;
        done = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    bus.valid_i = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: got ready_o=%0b want beat accepted", bus.ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b want 0", bus.valid_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b want 1", bus.ready_o); end
    n_checks++; if (bus.acc_resulting_number_o !== 49'd0) begin n_errors++; $display("FAIL reset_result: got %0h want 0", bus.acc_resulting_number_o); end
    n_checks++; if (bus.swap_o !== 1'b0) begin n_errors++; $display("FAIL reset_swap: got %0b want 0", bus.swap_o); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %0b want 0", bus.ovf); end
    n_checks++; if (bus.count_o !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
  endtask

  task automatic test_pass_add();
    bus.ready_i = 1'b1;
    drive_beat(48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL add_latency_early: got %0b want 0", bus.valid_o); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b1) begin n_errors++; $display("FAIL add_latency: got %0b want 1", bus.valid_o); end
    n_checks++; if (bus.acc_resulting_number_o !== 49'h1_0000_0000_0000) begin n_errors++; $display("FAIL add_result: got %0h want 1000000000000", bus.acc_resulting_number_o); end
    n_checks++; if (bus.ovf !== 1'b1) begin n_errors++; $display("FAIL add_ovf: got %0b want 1", bus.ovf); end
    n_checks++; if (bus.swap_o !== 1'b0) begin n_errors++; $display("FAIL add_swap: got %0b want 0", bus.swap_o); end
    n_checks++; if (bus.count_o !== 5'd1) begin n_errors++; $display("FAIL add_count: got %0d want 1", bus.count_o); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL add_drain: got %0b want 0", bus.valid_o); end
    drive_beat(48'd3, 48'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd7 || bus.ovf !== 1'b0) begin n_errors++; $display("FAIL add_small: got %0h ovf %0b want 7 ovf 0", bus.acc_resulting_number_o, bus.ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_pass_sub();
    bus.ready_i = 1'b1;
    drive_beat(48'd5, 48'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd4) begin n_errors++; $display("FAIL sub_swap_result: got %0h want 4", bus.acc_resulting_number_o); end
    n_checks++; if (bus.swap_o !== 1'b1) begin n_errors++; $display("FAIL sub_swap_flag: got %0b want 1", bus.swap_o); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL sub_swap_ovf: got %0b want 0", bus.ovf); end
    @(posedge clk); #1;
    drive_beat(48'd7, 48'd7, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd0 || bus.swap_o !== 1'b0) begin n_errors++; $display("FAIL sub_equal: got %0h swap %0b want 0 swap 0", bus.acc_resulting_number_o, bus.swap_o); end
    @(posedge clk); #1;
    drive_beat(48'd9, 48'd5, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd4 || bus.swap_o !== 1'b0) begin n_errors++; $display("FAIL sub_noswap: got %0h swap %0b want 4 swap 0", bus.acc_resulting_number_o, bus.swap_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [47:0] b_ab   [4];
    logic [47:0] b_c    [4];
    logic        b_sub  [4];
    logic [48:0] b_res  [4];
    logic        b_swap [4];
    b_ab[0] = 48'd1;   b_c[0] = 48'd2;   b_sub[0] = 1'b0; b_res[0] = 49'd3;   b_swap[0] = 1'b0;
    b_ab[1] = 48'd10;  b_c[1] = 48'd4;   b_sub[1] = 1'b1; b_res[1] = 49'd6;   b_swap[1] = 1'b0;
    b_ab[2] = 48'd4;   b_c[2] = 48'd10;  b_sub[2] = 1'b1; b_res[2] = 49'd6;   b_swap[2] = 1'b1;
    b_ab[3] = 48'd100; b_c[3] = 48'd200; b_sub[3] = 1'b0; b_res[3] = 49'd300; b_swap[3] = 1'b0;
    bus.ready_i = 1'b0;
    @(posedge clk); #2;
    fork
      begin
        for (int k = 0; k < 4; k++) drive_beat(b_ab[k], b_c[k], b_sub[k], 1'b0, 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          int w;
          w = 0;
          @(posedge clk); #1;
          while (bus.valid_o !== 1'b1 && w < 30) begin @(posedge clk); #1; w++; end
          n_checks++; if (bus.valid_o !== 1'b1) begin n_errors++; $display("FAIL b2b_wait[%0d]: got valid %0b want 1", k, bus.valid_o); end
          for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (bus.valid_o !== 1'b1 || bus.acc_resulting_number_o !== b_res[k] || bus.swap_o !== b_swap[k]) begin
              n_errors++; $display("FAIL b2b_stall[%0d]: got v%0b %0h swap %0b want v1 %0h swap %0b", k, bus.valid_o, bus.acc_resulting_number_o, bus.swap_o, b_res[k], b_swap[k]);
            end
            @(posedge clk); #1;
          end
          n_checks++;
          if (bus.valid_o !== 1'b1 || bus.acc_resulting_number_o !== b_res[k] || bus.swap_o !== b_swap[k] || bus.count_o !== 5'd1) begin
            n_errors++; $display("FAIL b2b_out[%0d]: got v%0b %0h swap %0b cnt %0d want v1 %0h swap %0b cnt 1", k, bus.valid_o, bus.acc_resulting_number_o, bus.swap_o, bus.count_o, b_res[k], b_swap[k]);
          end
          bus.ready_i = 1'b1;
          @(posedge clk); #1;
          bus.ready_i = 1'b0;
        end
      end
    join
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %0b want 0", bus.valid_o); end
    bus.ready_i = 1'b1;
  endtask

  task automatic test_accumulate();
    bus.ready_i = 1'b1;
    drive_beat(48'd10, 48'd0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (bus.ready_o !== 1'b0) begin n_errors++; $display("FAIL acc_busy_ready: got %0b want 0", bus.ready_o); end
    drive_beat(48'd25, 48'd0, 1'b1, 1'b1, 1'b0);
    bus.ready_i = 1'b0;
    drive_beat(48'd3, 48'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b1 || bus.acc_resulting_number_o !== 49'd12) begin n_errors++; $display("FAIL acc_result: got v%0b %0h want v1 c", bus.valid_o, bus.acc_resulting_number_o); end
    n_checks++; if (bus.swap_o !== 1'b1) begin n_errors++; $display("FAIL acc_sign: got %0b want 1", bus.swap_o); end
    n_checks++; if (bus.count_o !== 5'd3) begin n_errors++; $display("FAIL acc_count: got %0d want 3", bus.count_o); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL acc_ovf: got %0b want 0", bus.ovf); end
    n_checks++; if (bus.ready_o !== 1'b0) begin n_errors++; $display("FAIL acc_hold_ready: got %0b want 0", bus.ready_o); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b1 || bus.acc_resulting_number_o !== 49'd12) begin n_errors++; $display("FAIL acc_hold: got v%0b %0h want v1 c", bus.valid_o, bus.acc_resulting_number_o); end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL acc_release: got %0b want 0", bus.valid_o); end
    drive_beat(48'd6, 48'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd6 || bus.count_o !== 5'd1 || bus.swap_o !== 1'b0) begin n_errors++; $display("FAIL acc_cleared: got %0h cnt %0d swap %0b want 6 cnt 1 swap 0", bus.acc_resulting_number_o, bus.count_o, bus.swap_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bus.ready_i = 1'b1;
    drive_beat(48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b1, 1'b0);
    drive_beat(48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'h0_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL sat_result: got %0h want ffffffffffff", bus.acc_resulting_number_o); end
    n_checks++; if (bus.ovf !== 1'b1) begin n_errors++; $display("FAIL sat_ovf: got %0b want 1", bus.ovf); end
    n_checks++; if (bus.count_o !== 5'd2) begin n_errors++; $display("FAIL sat_count: got %0d want 2", bus.count_o); end
    @(posedge clk); #1;
    drive_beat(48'd1, 48'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd1 || bus.ovf !== 1'b0) begin n_errors++; $display("FAIL sat_sticky_clear: got %0h ovf %0b want 1 ovf 0", bus.acc_resulting_number_o, bus.ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_pass_interleave();
    bus.ready_i = 1'b1;
    drive_beat(48'd5, 48'd0, 1'b0, 1'b1, 1'b0);
    drive_beat(48'd2, 48'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (bus.valid_o !== 1'b1 || bus.acc_resulting_number_o !== 49'd5 || bus.count_o !== 5'd1) begin n_errors++; $display("FAIL mix_pass: got v%0b %0h cnt %0d want v1 5 cnt 1", bus.valid_o, bus.acc_resulting_number_o, bus.count_o); end
    @(posedge clk); #1;
    drive_beat(48'd1, 48'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd6 || bus.count_o !== 5'd2) begin n_errors++; $display("FAIL mix_acc: got %0h cnt %0d want 6 cnt 2", bus.acc_resulting_number_o, bus.count_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_counter_sat();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 32; i++) drive_beat(48'd1, 48'd0, 1'b0, 1'b1, 1'b0);
    drive_beat(48'd1, 48'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (bus.count_o !== 5'd31) begin n_errors++; $display("FAIL cnt_sat: got %0d want 31", bus.count_o); end
    n_checks++; if (bus.acc_resulting_number_o !== 49'd33) begin n_errors++; $display("FAIL cnt_sum: got %0h want 21", bus.acc_resulting_number_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    bus.ready_i = 1'b1;
    drive_beat(48'd7, 48'd0, 1'b0, 1'b1, 1'b0);
    drive_beat(48'd8, 48'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %0b want 0", bus.valid_o); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready: got %0b want 1", bus.ready_o); end
    drive_beat(48'd4, 48'd0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stale: got %0b want 0", bus.valid_o); end
    @(posedge clk); #1;
    n_checks++; if (bus.acc_resulting_number_o !== 49'd4 || bus.count_o !== 5'd1 || bus.ovf !== 1'b0) begin n_errors++; $display("FAIL rst_mid_result: got %0h cnt %0d ovf %0b want 4 cnt 1 ovf 0", bus.acc_resulting_number_o, bus.count_o, bus.ovf); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.ab_number_i = '0;
    bus.c_number_i  = '0;
    bus.sub         = 1'b0;
    bus.acc_mode_i  = 1'b0;
    bus.last_i      = 1'b0;
    bus.ready_i     = 1'b1;
    test_reset();
    test_pass_add();
    test_pass_sub();
    test_back_to_back();
    test_accumulate();
    test_saturation();
    test_pass_interleave();
    test_counter_sat();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
